// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_pkg
//  Purpose  : Shared definitions for the pipeline sequencing controller:
//             controller state encoding, P3 operand-forward select codes,
//             ISA opcode field constants and the forward-select helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // P3 ALU operand source selects
  localparam logic [1:0] FWD_REG = 2'd0;  // register file read in P2
  localparam logic [1:0] FWD_P4  = 2'd1;  // ALU result sitting in P4
  localparam logic [1:0] FWD_P5  = 2'd2;  // writeback value in P5

  // Opcode fields (op1 = IR[15:14], op3 = IR[3:0] for the system group)
  localparam logic [1:0] OP1_LD  = 2'b00;
  localparam logic [1:0] OP1_ST  = 2'b01;
  localparam logic [3:0] OP3_IN  = 4'b1100;
  localparam logic [3:0] OP3_OUT = 4'b1101;
  localparam logic [3:0] OP3_HLT = 4'b1111;

  // Forward select for one P3 source register. A load in P4 has no data
  // yet, so it never forwards; the younger P4 producer wins over P5.
  function automatic logic [1:0] fwd_sel(
    input logic [2:0] src,
    input logic       p4_valid,
    input logic       p4_wr_en,
    input logic       p4_is_load,
    input logic [2:0] p4_wr_addr,
    input logic       p5_valid,
    input logic       p5_wr_en,
    input logic [2:0] p5_wr_addr
  );
    if (p4_valid && p4_wr_en && !p4_is_load && (src == p4_wr_addr))
      return FWD_P4;
    else if (p5_valid && p5_wr_en && (src == p5_wr_addr))
      return FWD_P5;
    else
      return FWD_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_unit
//  Purpose  : Combinational load-use stall detection and P3 operand forward
//             select generation.
//  Ports    : p3_* - P3 source usage/registers
//             p4_* - P4 destination/write/load info
//             p5_* - P5 destination/write info
//             stall        - load-use hazard between P3 and a load in P4
//             fwd_a, fwd_b - operand source selects for ALU inputs A/B
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       p3_valid,
  input  logic       p3_use_a,
  input  logic       p3_use_b,
  input  logic [2:0] p3_ra,
  input  logic [2:0] p3_rb,
  input  logic       p4_valid,
  input  logic       p4_wr_en,
  input  logic [2:0] p4_wr_addr,
  input  logic       p4_is_load,
  input  logic       p5_valid,
  input  logic       p5_wr_en,
  input  logic [2:0] p5_wr_addr,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic hit_a;
  logic hit_b;

  always_comb begin
    // Only real reads of the loaded register stall; forwarding below
    // ignores use flags because an unused select is harmless.
    hit_a = p3_use_a && (p3_ra == p4_wr_addr);
    hit_b = p3_use_b && (p3_rb == p4_wr_addr);
    stall = p3_valid && p4_valid && p4_is_load && p4_wr_en && (hit_a || hit_b);
    fwd_a = fwd_sel(p3_ra, p4_valid, p4_wr_en, p4_is_load, p4_wr_addr,
                    p5_valid, p5_wr_en, p5_wr_addr);
    fwd_b = fwd_sel(p3_rb, p4_valid, p4_wr_en, p4_is_load, p4_wr_addr,
                    p5_valid, p5_wr_en, p5_wr_addr);
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Sequencing controller for the 5-stage pipeline. Owns run/halt
//             state and PC enable, stalls on load-use, selects P3 operand
//             forwarding, flushes P2/P3 on taken branch/HALT/pause and counts
//             retired instructions.
//  Ports    : clock, reset (sync, active-high); exec run/stop request level;
//             p3_*/p4_*/p5_* pipeline-register fields;
//             pc_en, pc_load, hold_p123, bubble_p4, flush_p2, flush_p3 stage
//             controls; fwd_a/fwd_b operand selects; running/halted status;
//             retired instruction count.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exec,
  input  logic             p3_valid,
  input  logic             p3_use_a,
  input  logic             p3_use_b,
  input  logic [2:0]       p3_ra,
  input  logic [2:0]       p3_rb,
  input  logic             p3_is_halt,
  input  logic             p3_br_taken,
  input  logic             p4_valid,
  input  logic             p4_wr_en,
  input  logic [2:0]       p4_wr_addr,
  input  logic             p4_is_load,
  input  logic             p5_valid,
  input  logic             p5_wr_en,
  input  logic [2:0]       p5_wr_addr,
  output logic             pc_en,
  output logic             pc_load,
  output logic             hold_p123,
  output logic             bubble_p4,
  output logic             flush_p2,
  output logic             flush_p3,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             exec_q, exec_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             exec_edge;
  logic             stall;

  hazard_fwd_unit u_hazard_fwd_unit (
    .p3_valid   (p3_valid),
    .p3_use_a   (p3_use_a),
    .p3_use_b   (p3_use_b),
    .p3_ra      (p3_ra),
    .p3_rb      (p3_rb),
    .p4_valid   (p4_valid),
    .p4_wr_en   (p4_wr_en),
    .p4_wr_addr (p4_wr_addr),
    .p4_is_load (p4_is_load),
    .p5_valid   (p5_valid),
    .p5_wr_en   (p5_wr_en),
    .p5_wr_addr (p5_wr_addr),
    .stall      (stall),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      exec_q      <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      exec_q      <= exec_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    exec_d    = exec;
    exec_edge = exec && !exec_q;
    retired_d = retired_q + CNT_W'(p5_valid);

    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    hold_p123   = 1'b0;
    bubble_p4   = 1'b0;
    flush_p2    = 1'b0;
    flush_p3    = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        // Pipeline kept empty while stopped; PC is untouched so a resume
        // after HALTED continues at the next fetch.
        flush_p2 = 1'b1;
        flush_p3 = 1'b1;
        if (exec_edge) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (stall) begin
          // The stall owns this cycle; a branch in P3 is held and acts once
          // the load reaches P5. An exec edge landing here is not acted on.
          hold_p123 = 1'b1;
          bubble_p4 = 1'b1;
        end else if (p3_valid && p3_is_halt) begin
          flush_p2    = 1'b1;
          flush_p3    = 1'b1;
          drain_cnt_d = DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end else if (p3_valid && p3_br_taken) begin
          pc_load  = 1'b1;
          flush_p2 = 1'b1;
          flush_p3 = 1'b1;
        end else if (exec_edge) begin
          // Pause: the flushed P2/P3 instructions are refetched on resume.
          flush_p2    = 1'b1;
          flush_p3    = 1'b1;
          drain_cnt_d = DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end else begin
          pc_en = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Let P4 and P5 retire; exec edges are deliberately ignored here.
        flush_p2 = 1'b1;
        flush_p3 = 1'b1;
        if (drain_cnt_q == '0) state_d = ST_HALTED;
        else                   drain_cnt_d = drain_cnt_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign running = (state_q == ST_RUN);
  assign halted  = (state_q == ST_HALTED);
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Directed self-checking bench for pipeline_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        exec;
  logic        p3_valid, p3_use_a, p3_use_b, p3_is_halt, p3_br_taken;
  logic [2:0]  p3_ra, p3_rb;
  logic        p4_valid, p4_wr_en, p4_is_load;
  logic [2:0]  p4_wr_addr;
  logic        p5_valid, p5_wr_en;
  logic [2:0]  p5_wr_addr;
  logic        pc_en, pc_load, hold_p123, bubble_p4, flush_p2, flush_p3;
  logic [1:0]  fwd_a, fwd_b;
  logic        running, halted;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .exec        (exec),
    .p3_valid    (p3_valid),
    .p3_use_a    (p3_use_a),
    .p3_use_b    (p3_use_b),
    .p3_ra       (p3_ra),
    .p3_rb       (p3_rb),
    .p3_is_halt  (p3_is_halt),
    .p3_br_taken (p3_br_taken),
    .p4_valid    (p4_valid),
    .p4_wr_en    (p4_wr_en),
    .p4_wr_addr  (p4_wr_addr),
    .p4_is_load  (p4_is_load),
    .p5_valid    (p5_valid),
    .p5_wr_en    (p5_wr_en),
    .p5_wr_addr  (p5_wr_addr),
    .pc_en       (pc_en),
    .pc_load     (pc_load),
    .hold_p123   (hold_p123),
    .bubble_p4   (bubble_p4),
    .flush_p2    (flush_p2),
    .flush_p3    (flush_p3),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .running     (running),
    .halted      (halted),
    .retired     (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_pipe();
    p3_valid = 0; p3_use_a = 0; p3_use_b = 0; p3_ra = 0; p3_rb = 0;
    p3_is_halt = 0; p3_br_taken = 0;
    p4_valid = 0; p4_wr_en = 0; p4_wr_addr = 0; p4_is_load = 0;
    p5_valid = 0; p5_wr_en = 0; p5_wr_addr = 0;
  endtask

  initial begin
    reset = 1; exec = 0;
    clear_pipe();

    // Reset held for two cycles
    tick();
    chk("rst_pc_en", pc_en, 0);
    chk("rst_flush_p2", flush_p2, 1);
    chk("rst_retired", retired, 0);
    tick();
    reset = 0;
    tick();
    #1;
    chk("idle_pc_en", pc_en, 0);
    chk("idle_flush_p2", flush_p2, 1);
    chk("idle_flush_p3", flush_p3, 1);
    chk("idle_running", running, 0);
    chk("idle_halted", halted, 0);
    chk("idle_hold", hold_p123, 0);

    // Forwarding is active even in IDLE
    p4_valid = 1; p4_wr_en = 1; p4_wr_addr = 3'd1; p3_ra = 3'd1;
    #1;
    chk("idle_fwd_a", fwd_a, 1);
    clear_pipe();

    // exec edge -> RUN on the next cycle
    exec = 1;
    tick();
    #1;
    chk("run_running", running, 1);
    chk("run_pc_en", pc_en, 1);
    chk("run_flush_p2", flush_p2, 0);
    exec = 0;

    // Forwarding: P4 and P5 both write r2, P4 wins; then P5 only
    p3_valid = 1; p3_use_a = 1; p3_ra = 3'd2; p3_rb = 3'd5;
    p4_valid = 1; p4_wr_en = 1; p4_wr_addr = 3'd2;
    p5_valid = 1; p5_wr_en = 1; p5_wr_addr = 3'd2;
    #1;
    chk("fwd_a_p4", fwd_a, 1);
    chk("fwd_b_none", fwd_b, 0);
    p4_wr_en = 0;
    #1;
    chk("fwd_a_p5", fwd_a, 2);
    chk("fwd_pc_en", pc_en, 1);
    clear_pipe();

    // Load-use stall: LD r3 in P4, P3 reads rb=r3
    p3_valid = 1; p3_use_b = 1; p3_rb = 3'd3;
    p4_valid = 1; p4_wr_en = 1; p4_is_load = 1; p4_wr_addr = 3'd3;
    #1;
    chk("stall_pc_en", pc_en, 0);
    chk("stall_hold", hold_p123, 1);
    chk("stall_bubble", bubble_p4, 1);
    chk("stall_fwd_b", fwd_b, 0);
    tick();
    p4_valid = 0; p4_wr_en = 0; p4_is_load = 0;
    p5_valid = 1; p5_wr_en = 1; p5_wr_addr = 3'd3;
    #1;
    chk("post_stall_fwd_b", fwd_b, 2);
    chk("post_stall_pc_en", pc_en, 1);
    chk("post_stall_hold", hold_p123, 0);
    clear_pipe();
    tick();

    // Taken branch, no stall
    p3_valid = 1; p3_br_taken = 1;
    #1;
    chk("br_pc_load", pc_load, 1);
    chk("br_pc_en", pc_en, 0);
    chk("br_flush_p2", flush_p2, 1);
    chk("br_flush_p3", flush_p3, 1);
    tick();
    clear_pipe();
    #1;
    chk("br_done_pc_load", pc_load, 0);
    chk("br_done_pc_en", pc_en, 1);

    // Branch during a stall is deferred to the following cycle
    p3_valid = 1; p3_use_a = 1; p3_ra = 3'd4; p3_br_taken = 1;
    p4_valid = 1; p4_wr_en = 1; p4_is_load = 1; p4_wr_addr = 3'd4;
    #1;
    chk("br_stall_pc_load", pc_load, 0);
    chk("br_stall_hold", hold_p123, 1);
    tick();
    p4_valid = 0; p4_wr_en = 0; p4_is_load = 0;
    #1;
    chk("br_after_stall_pc_load", pc_load, 1);
    chk("br_after_stall_hold", hold_p123, 0);
    clear_pipe();
    tick();

    // HALT with a simultaneous taken branch: HALT wins
    p3_valid = 1; p3_is_halt = 1; p3_br_taken = 1;
    #1;
    chk("halt_pc_load", pc_load, 0);
    chk("halt_pc_en", pc_en, 0);
    chk("halt_flush_p2", flush_p2, 1);
    tick();
    clear_pipe();
    // DRAIN cycle 1; exec edge here must be ignored
    p5_valid = 1; exec = 1;
    #1;
    chk("drain1_running", running, 0);
    chk("drain1_halted", halted, 0);
    chk("drain1_pc_en", pc_en, 0);
    chk("drain1_flush_p3", flush_p3, 1);
    tick();
    chk("drain2_halted", halted, 0);
    chk("drain2_running", running, 0);
    tick();
    chk("halted_halted", halted, 1);
    chk("halted_pc_en", pc_en, 0);
    chk("halted_flush_p2", flush_p2, 1);
    tick();
    p5_valid = 0;
    #1;
    chk("retired_3", retired, 16'd3);
    chk("halted_still", halted, 1);
    exec = 0;
    tick();
    exec = 1;
    tick();
    chk("resume_running", running, 1);
    chk("resume_pc_en", pc_en, 1);

    // Pause via exec edge in RUN, then reset while draining
    exec = 0;
    tick();
    exec = 1;
    #1;
    chk("pause_pc_en", pc_en, 0);
    chk("pause_flush_p2", flush_p2, 1);
    tick();
    chk("pause_drain_running", running, 0);
    chk("pause_drain_halted", halted, 0);
    exec = 0;
    reset = 1;
    tick();
    chk("rst_drain_retired", retired, 0);
    chk("rst_drain_running", running, 0);
    chk("rst_drain_flush_p2", flush_p2, 1);
    reset = 0;
    tick();
    tick();
    chk("rst_drain_idle_halted", halted, 0);
    chk("rst_drain_idle_pc_en", pc_en, 0);

    // Retired counter wrap
    p5_valid = 1;
    for (int i = 0; i < 65535; i++) @(posedge clock);
    #1;
    chk("retired_ffff", retired, 16'hFFFF);
    tick();
    p5_valid = 0;
    #1;
    chk("retired_wrap", retired, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
